// File: rtl/apb_plic_pkg.sv
// Shared types and address helpers for the PLIC claim/complete APB initiator.
package apb_plic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLM_SETUP,
        CLM_ACCESS,
        PRESENT,
        CMP_SETUP,
        CMP_ACCESS
    } state_e;

    localparam logic [31:0] CC_BASE_OFFSET   = 32'h0020_0004;
    localparam logic [31:0] CC_TARGET_STRIDE = 32'h0000_1000;

    function automatic logic [31:0] cc_addr(input logic [31:0] base, input int unsigned target);
        return base + CC_BASE_OFFSET + 32'(target) * CC_TARGET_STRIDE;
    endfunction

endpackage

// File: rtl/apb_master_xfer.sv
// Generic single-transfer APB3 initiator: one req starts SETUP then ACCESS.
// ack is a combinational pulse in the ACCESS cycle that sees pready; bus outputs are registered.
module apb_master_xfer #(
    parameter logic [31:0] ADDR_RST = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= ADDR_RST;
            pwdata  <= 32'h0;
        end else if (!psel) begin
            if (req) begin
                psel   <= 1'b1;
                pwrite <= write;
                paddr  <= addr;
                if (write) begin
                    pwdata <= wdata;
                end
            end
        end else if (!penable) begin
            penable <= 1'b1;
        end else if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
        end
    end

    assign ack   = psel & penable & pready;
    assign rdata = prdata;
    assign err   = pslverr;

endmodule

// File: rtl/apb_plic_claim_master.sv
// Claims PLIC interrupt IDs over APB on eip_i and writes completions back; claim latency 3 cycles.
// Optional macro APB_PLIC_CLAIM_EIP_SYNC_EN adds a 2-flop eip_i synchronizer.
module apb_plic_claim_master
    import apb_plic_pkg::*;
#(
    parameter int unsigned N_SOURCE       = 30,
    parameter int unsigned SRCW           = $clog2(N_SOURCE + 1),
    parameter int unsigned TARGET_ID      = 0,
    parameter logic [31:0] BASE_ADDR      = 32'h0C00_0000,
    parameter int unsigned HOLDOFF_CYCLES = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            eip_i,
    output logic [31:0]     paddr_o,
    output logic            psel_o,
    output logic            penable_o,
    output logic            pwrite_o,
    output logic [31:0]     pwdata_o,
    input  logic [31:0]     prdata_i,
    input  logic            pready_i,
    input  logic            pslverr_i,
    output logic            irq_valid_o,
    input  logic            irq_ready_i,
    output logic [SRCW-1:0] irq_id_o,
    input  logic            cmpl_valid_i,
    input  logic [SRCW-1:0] cmpl_id_i,
    output logic            cmpl_ready_o,
    output logic            err_o,
    output logic            spurious_o
);

    localparam logic [31:0] CC_ADDR = cc_addr(BASE_ADDR, TARGET_ID);
    localparam int unsigned HW      = $clog2(HOLDOFF_CYCLES + 2);

    state_e          state_q, state_d;
    logic            eip;
    logic [HW-1:0]   hold_cnt;
    logic            req, wr, ack, xerr, id_load, hold_load;
    logic [31:0]     rdata;
    logic [SRCW-1:0] claim_id;
    logic            upper_set;

`ifdef APB_PLIC_CLAIM_EIP_SYNC_EN
    logic [1:0] eip_sync;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            eip_sync <= 2'b00;
        end else begin
            eip_sync <= {eip_sync[0], eip_i};
        end
    end
    assign eip = eip_sync[1];
`else
    assign eip = eip_i;
`endif

    assign claim_id  = rdata[SRCW-1:0];
    assign upper_set = |rdata[31:SRCW];

    apb_master_xfer #(.ADDR_RST(CC_ADDR)) u_xfer (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req     (req),
        .write   (wr),
        .addr    (CC_ADDR),
        .wdata   ({{(32-SRCW){1'b0}}, cmpl_id_i}),
        .ack     (ack),
        .rdata   (rdata),
        .err     (xerr),
        .psel    (psel_o),
        .penable (penable_o),
        .pwrite  (pwrite_o),
        .paddr   (paddr_o),
        .pwdata  (pwdata_o),
        .prdata  (prdata_i),
        .pready  (pready_i),
        .pslverr (pslverr_i)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            irq_id_o <= '0;
            hold_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (id_load) begin
                irq_id_o <= claim_id;
            end
            if (hold_load) begin
                hold_cnt <= HW'(HOLDOFF_CYCLES);
            end else if (hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
            end
        end
    end

    // Completion takes priority so a waiting consumer is never starved by a busy eip_i.
    always_comb begin
        state_d      = state_q;
        req          = 1'b0;
        wr           = 1'b0;
        id_load      = 1'b0;
        hold_load    = 1'b0;
        cmpl_ready_o = 1'b0;
        err_o        = 1'b0;
        spurious_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmpl_valid_i) begin
                    req     = 1'b1;
                    wr      = 1'b1;
                    state_d = CMP_SETUP;
                end else if (eip && hold_cnt == '0) begin
                    req     = 1'b1;
                    state_d = CLM_SETUP;
                end
            end
            CLM_SETUP: state_d = CLM_ACCESS;
            CLM_ACCESS: begin
                if (ack) begin
                    hold_load = 1'b1;
                    state_d   = IDLE;
                    if (xerr) begin
                        err_o = 1'b1;
                    end else if (claim_id == '0) begin
                        spurious_o = 1'b1;
                    end else if (claim_id > SRCW'(N_SOURCE) || upper_set) begin
                        err_o = 1'b1;
                    end else begin
                        id_load = 1'b1;
                        state_d = PRESENT;
                    end
                end
            end
            PRESENT: begin
                if (irq_ready_i) begin
                    state_d = IDLE;
                end
            end
            CMP_SETUP: state_d = CMP_ACCESS;
            CMP_ACCESS: begin
                if (ack) begin
                    cmpl_ready_o = 1'b1;
                    err_o        = xerr;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign irq_valid_o = (state_q == PRESENT);

endmodule

// File: tb/tb_apb_plic_claim_master.sv
// Scoreboard bench: APB slave model predicts each transfer's outcome, a monitor checks DUT outputs.
module tb_apb_plic_claim_master;

    localparam int unsigned N_SOURCE = 30;
    localparam int unsigned SRCW     = 5;
    localparam int unsigned HOLDOFF  = 4;
    localparam logic [31:0] CC_ADDR  = 32'h0C20_0004;

    localparam int R_ID = 0, R_SPUR = 1, R_ERR = 2, R_WOK = 3, R_WERR = 4;

    typedef struct {
        int unsigned waits;
        logic [31:0] data;
        logic        err;
    } plan_t;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            eip_i;
    logic [31:0]     paddr_o, pwdata_o, prdata_i;
    logic            psel_o, penable_o, pwrite_o, pready_i, pslverr_i;
    logic            irq_valid_o, irq_ready_i, cmpl_valid_i, cmpl_ready_o, err_o, spurious_o;
    logic [SRCW-1:0] irq_id_o, cmpl_id_i;

    int vectors = 0, miscompares = 0;
    plan_t           plan_q[$];
    int              resp_q[$];
    logic [SRCW-1:0] id_q[$];
    logic [SRCW-1:0] cmpl_q[$];
    bit              rand_en = 0;
    bit              dir_ready = 0;
    int              req_cnt = 0, done_cnt = 0;
    logic [SRCW-1:0] req_id = '0;
    plan_t           cur;
    int unsigned     wcnt;

    always #5 clk_i = ~clk_i;

    apb_plic_claim_master dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .eip_i(eip_i),
        .paddr_o(paddr_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
        .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
        .irq_valid_o(irq_valid_o), .irq_ready_i(irq_ready_i), .irq_id_o(irq_id_o),
        .cmpl_valid_i(cmpl_valid_i), .cmpl_id_i(cmpl_id_i), .cmpl_ready_o(cmpl_ready_o),
        .err_o(err_o), .spurious_o(spurious_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic plan_t mk(input int unsigned w, input logic [31:0] d, input logic e);
        plan_t p;
        p.waits = w;
        p.data  = d;
        p.err   = e;
        return p;
    endfunction

    function automatic plan_t rnd_plan();
        plan_t p;
        int unsigned r;
        r       = $urandom_range(0, 9);
        p.waits = $urandom_range(0, 2);
        p.err   = 1'b0;
        p.data  = $urandom_range(1, N_SOURCE);
        case (r)
            0: p.err  = 1'b1;
            1: p.data = 32'h0;
            2: p.data = $urandom_range(N_SOURCE + 1, 31);
            3: p.data = $urandom() | 32'h0000_0100;
            default: ;
        endcase
        return p;
    endfunction

    // APB slave: responds after the planned wait states and predicts the DUT reaction.
    initial begin
        pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = '0; wcnt = 0;
        cur = mk(0, 0, 0);
        forever begin
            @(posedge clk_i); #1;
            pready_i  = 1'b0;
            pslverr_i = 1'($urandom_range(0, 1));
            prdata_i  = $urandom();
            if (psel_o && !penable_o) begin
                cur  = (plan_q.size() > 0) ? plan_q.pop_front() : rnd_plan();
                wcnt = cur.waits;
            end else if (psel_o && penable_o) begin
                if (wcnt == 0) begin
                    pready_i  = 1'b1;
                    prdata_i  = cur.data;
                    pslverr_i = cur.err;
                    if (pwrite_o)                         resp_q.push_back(cur.err ? R_WERR : R_WOK);
                    else if (cur.err)                     resp_q.push_back(R_ERR);
                    else if (cur.data[SRCW-1:0] == '0)    resp_q.push_back(R_SPUR);
                    else if (cur.data > N_SOURCE)         resp_q.push_back(R_ERR);
                    else begin
                        resp_q.push_back(R_ID);
                        id_q.push_back(cur.data[SRCW-1:0]);
                    end
                end else begin
                    wcnt--;
                end
            end
        end
    end

    // Consumer: acceptance, completion requests; holds cmpl_valid until the monitor sees cmpl_ready.
    initial begin
        int srv = 0, seen = 0;
        logic [SRCW-1:0] id;
        irq_ready_i = 1'b0; cmpl_valid_i = 1'b0; cmpl_id_i = '0;
        forever begin
            @(posedge clk_i); #2;
            irq_ready_i = rand_en ? 1'($urandom_range(0, 1)) : dir_ready;
            if (cmpl_valid_i) begin
                if (done_cnt != seen) begin
                    seen++;
                    cmpl_valid_i = 1'b0;
                end
            end else if (req_cnt != srv) begin
                srv++;
                cmpl_valid_i = 1'b1; cmpl_id_i = req_id; cmpl_q.push_back(req_id);
            end else if (rand_en && $urandom_range(0, 15) == 0) begin
                id = SRCW'($urandom_range(0, 31));
                cmpl_valid_i = 1'b1; cmpl_id_i = id; cmpl_q.push_back(id);
            end
        end
    end

    // Monitor
    initial begin
        int r;
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                if (psel_o && penable_o && pready_i) begin
                    chk("paddr", paddr_o, CC_ADDR);
                    if (resp_q.size() == 0) begin
                        chk("resp_expected", 0, 1);
                    end else begin
                        r = resp_q.pop_front();
                        chk("err_pulse", err_o, (r == R_ERR || r == R_WERR));
                        chk("spurious_pulse", spurious_o, (r == R_SPUR));
                        chk("cmpl_ready_pulse", cmpl_ready_o, (r >= R_WOK));
                    end
                    if (pwrite_o) begin
                        if (cmpl_q.size() == 0) chk("write_requested", 0, 1);
                        else chk("pwdata", pwdata_o, 32'(cmpl_q.pop_front()));
                        done_cnt++;
                    end
                end else if (err_o || spurious_o || cmpl_ready_o) begin
                    chk("stray_pulse", {err_o, spurious_o, cmpl_ready_o}, 0);
                end
                if (irq_valid_o) begin
                    if (id_q.size() == 0) chk("irq_expected", 0, 1);
                    else begin
                        chk("irq_id", irq_id_o, id_q[0]);
                        if (irq_ready_i) void'(id_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, k, cnt, fall, rise, seen_irq, busy;
        logic prev;
        logic w[2];
        rst_ni = 1'b0; eip_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_psel", psel_o, 0);       chk("rst_penable", penable_o, 0);
        chk("rst_pwrite", pwrite_o, 0);   chk("rst_paddr", paddr_o, CC_ADDR);
        chk("rst_pwdata", pwdata_o, 0);   chk("rst_irq_valid", irq_valid_o, 0);
        chk("rst_irq_id", irq_id_o, 0);
        chk("rst_pulses", {cmpl_ready_o, err_o, spurious_o}, 0);
        rst_ni = 1'b1;

        // Claim with zero wait states: irq_valid three cycles after eip_i.
        repeat (2) @(posedge clk_i);
        plan_q.push_back(mk(0, 32'd5, 0));
        #1 eip_i = 1'b1;
        n = 0;
        while (!irq_valid_o && n < 20) begin @(posedge clk_i); #1; n++; end
        chk("claim_latency", n, 3);
        eip_i = 1'b0; dir_ready = 1'b1;
        @(posedge clk_i); #1 dir_ready = 1'b0;

        // Completion of ID 5 with two wait states: penable high for three cycles.
        repeat (2) @(posedge clk_i);
        plan_q.push_back(mk(2, 0, 0));
        #1 req_id = 5; req_cnt++;
        n = 0; k = 0;
        @(posedge clk_i); #1;
        while ((cmpl_valid_i || psel_o) && k < 30) begin
            if (psel_o && penable_o) n++;
            @(posedge clk_i); #1; k++;
        end
        chk("cmpl_penable_cycles", n, 3);

        // Completion and eip in the same cycle: write goes first.
        repeat (2) @(posedge clk_i);
        plan_q.push_back(mk(0, 0, 0));
        plan_q.push_back(mk(0, 32'd7, 0));
        dir_ready = 1'b1;
        #1 eip_i = 1'b1; req_id = 3; req_cnt++;
        cnt = 0; prev = 1'b0; w[0] = 1'bx; w[1] = 1'bx;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk_i); #1;
            if (psel_o && !prev && cnt < 2) begin
                w[cnt] = pwrite_o; cnt++;
                if (cnt == 2) eip_i = 1'b0;
            end
            prev = psel_o;
        end
        chk("order_xfer_count", cnt, 2);
        chk("order_first_write", w[0], 1);
        chk("order_then_read", w[1], 0);

        // Spurious claim; with eip held the next claim waits one IDLE cycle plus the hold-off.
        plan_q.push_back(mk(0, 32'd0, 0));
        plan_q.push_back(mk(0, 32'd9, 0));
        @(posedge clk_i); #1 eip_i = 1'b1;
        prev = 1'b0; fall = -1; rise = -1; seen_irq = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i); #1;
            if (prev && !psel_o && fall < 0) fall = i;
            if (!prev && psel_o && fall >= 0 && rise < 0) begin rise = i; eip_i = 1'b0; end
            if (irq_valid_o && rise < 0) seen_irq = 1;
            prev = psel_o;
        end
        chk("spurious_no_irq", seen_irq, 0);
        chk("holdoff_gap", rise - fall, HOLDOFF + 1);

        // Slave error, then out-of-range ID 31: neither presents an interrupt.
        plan_q.push_back(mk(0, 32'd3, 1));
        plan_q.push_back(mk(0, 32'd31, 0));
        @(posedge clk_i); #1 eip_i = 1'b1;
        cnt = 0; prev = 1'b0; seen_irq = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk_i); #1;
            if (!prev && psel_o) begin cnt++; if (cnt == 2) eip_i = 1'b0; end
            if (irq_valid_o) seen_irq = 1;
            prev = psel_o;
        end
        chk("err_claims_seen", cnt, 2);
        chk("err_no_irq", seen_irq, 0);

        // Consumer stalls ten cycles: ID must stay presented.
        dir_ready = 1'b0;
        plan_q.push_back(mk(0, 32'd12, 0));
        @(posedge clk_i); #1 eip_i = 1'b1;
        n = 0;
        while (!irq_valid_o && n < 20) begin @(posedge clk_i); #1; n++; end
        eip_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        chk("stall_valid_held", irq_valid_o, 1);
        chk("stall_id_held", irq_id_o, 12);
        dir_ready = 1'b1;
        @(posedge clk_i); #1 dir_ready = 1'b0;

        // Reset in the middle of a claim ACCESS phase.
        repeat (8) @(posedge clk_i);
        plan_q.push_back(mk(3, 32'd1, 0));
        #1 eip_i = 1'b1;
        n = 0;
        while (!(psel_o && penable_o) && n < 20) begin @(posedge clk_i); #1; n++; end
        #2 rst_ni = 1'b0; eip_i = 1'b0;
        #1;
        chk("amid_psel", psel_o, 0);       chk("amid_penable", penable_o, 0);
        chk("amid_pwrite", pwrite_o, 0);   chk("amid_pwdata", pwdata_o, 0);
        chk("amid_paddr", paddr_o, CC_ADDR);
        chk("amid_irq_id", irq_id_o, 0);   chk("amid_irq_valid", irq_valid_o, 0);
        repeat (2) @(posedge clk_i);
        #3 rst_ni = 1'b1;

        // Randomized traffic.
        rand_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk_i); #1;
            if ($urandom_range(0, 7) == 0) eip_i = ~eip_i;
        end
        rand_en = 1'b0; eip_i = 1'b0; dir_ready = 1'b1;
        busy = 1; k = 0;
        while (busy && k < 200) begin
            @(posedge clk_i); #1; k++;
            busy = (psel_o || irq_valid_o || cmpl_valid_i) ? 1 : 0;
        end
        chk("drain_idle", busy, 0);
        repeat (10) @(posedge clk_i);
        chk("resp_q_drained", resp_q.size(), 0);
        chk("id_q_drained", id_q.size(), 0);
        chk("cmpl_q_drained", cmpl_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
